// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus between calculator datapath and converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned DIGITS = 5
);

  logic                  start;
  logic [IN_W-1:0]       value;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  ovf;

  modport master (
    output start, value,
    input  busy, done, bcd, neg, ovf
  );

  modport slave (
    input  start, value,
    output busy, done, bcd, neg, ovf
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_ADJ_THRESH) begin
      digit_o = digit_i + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock, feeding the seven-segment
// decoders with packed BCD digits plus a sign flag.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned DIGITS = 5,
  parameter bit          SIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  bin_to_bcd_seq_if.slave conv
);

  localparam int unsigned CntW = $clog2(IN_W + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   mag_q, mag_d;
  logic [BcdW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_pend_q, neg_pend_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;

  logic [BcdW-1:0]   acc_adj;
  logic [BcdW-1:0]   acc_shift;
  logic              ovf_shift;
  logic              last_iter;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  // The bit leaving the top digit is the overflow carry; magnitude MSB enters digit 0.
  assign {ovf_shift, acc_shift} = {acc_adj, mag_q[IN_W-1]};
  assign last_iter = (cnt_q == CntW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (conv.start) state_d = StShift;
      StShift: if (last_iter)  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    conv.busy = (state_q != StIdle);
    conv.done = (state_q == StDone);
  end

  assign conv.bcd = bcd_q;
  assign conv.neg = neg_q;
  assign conv.ovf = ovf_q;

  always_comb begin
    mag_d      = mag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_pend_d = neg_pend_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (conv.start) begin
          neg_pend_d = SIGNED && conv.value[IN_W-1];
          // Negation is taken IN_W bits wide, so the most negative value maps to 2^(IN_W-1).
          mag_d      = neg_pend_d ? ((~conv.value) + {{(IN_W-1){1'b0}}, 1'b1}) : conv.value;
          acc_d      = '0;
          cnt_d      = CntW'(IN_W);
          ovf_pend_d = 1'b0;
        end
      end
      StShift: begin
        acc_d      = acc_shift;
        mag_d      = {mag_q[IN_W-2:0], 1'b0};
        ovf_pend_d = ovf_pend_q | ovf_shift;
        cnt_d      = cnt_q - CntW'(1);
        // Results are published on entry to StDone so they hold steady between conversions.
        if (last_iter) begin
          bcd_d = acc_shift;
          neg_d = neg_pend_q;
          ovf_d = ovf_pend_q | ovf_shift;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_pend_q <= neg_pend_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: signed default, unsigned, and 4-digit overflow variants.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0]  start_r = 3'b000;
  logic [15:0] value_r = 16'h0000;
  int          sel = 0;

  bin_to_bcd_seq_if #(.IN_W(16), .DIGITS(5)) if_a ();
  bin_to_bcd_seq_if #(.IN_W(16), .DIGITS(5)) if_b ();
  bin_to_bcd_seq_if #(.IN_W(16), .DIGITS(4)) if_c ();

  assign if_a.start = start_r[0];
  assign if_b.start = start_r[1];
  assign if_c.start = start_r[2];
  assign if_a.value = value_r;
  assign if_b.value = value_r;
  assign if_c.value = value_r;

  bin_to_bcd_seq #(.IN_W(16), .DIGITS(5), .SIGNED(1'b1)) u_dut_a (
    .clk  (clk),
    .rst  (rst),
    .conv (if_a)
  );
  bin_to_bcd_seq #(.IN_W(16), .DIGITS(5), .SIGNED(1'b0)) u_dut_b (
    .clk  (clk),
    .rst  (rst),
    .conv (if_b)
  );
  bin_to_bcd_seq #(.IN_W(16), .DIGITS(4), .SIGNED(1'b0)) u_dut_c (
    .clk  (clk),
    .rst  (rst),
    .conv (if_c)
  );

  logic        busy_m, done_m, neg_m, ovf_m;
  logic [19:0] bcd_m;

  always_comb begin
    busy_m = if_a.busy;
    done_m = if_a.done;
    neg_m  = if_a.neg;
    ovf_m  = if_a.ovf;
    bcd_m  = if_a.bcd;
    if (sel == 1) begin
      busy_m = if_b.busy;
      done_m = if_b.done;
      neg_m  = if_b.neg;
      ovf_m  = if_b.ovf;
      bcd_m  = if_b.bcd;
    end else if (sel == 2) begin
      busy_m = if_c.busy;
      done_m = if_c.done;
      neg_m  = if_c.neg;
      ovf_m  = if_c.ovf;
      bcd_m  = {4'h0, if_c.bcd};
    end
  end

  // One-cycle start, then wait (bounded) for done; lat is -1 if done never arrives.
  task automatic convert(input int which, input logic [15:0] v, output logic [19:0] r_bcd,
                         output logic r_neg, output logic r_ovf, output int lat,
                         output int bcnt);
    sel = which;
    @(negedge clk);
    value_r = v;
    start_r[which] = 1'b1;
    @(posedge clk);
    #1 start_r[which] = 1'b0;
    lat = -1;
    bcnt = 0;
    r_bcd = '0;
    r_neg = 1'b0;
    r_ovf = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy_m) bcnt++;
      if (done_m) begin
        lat = i;
        r_bcd = bcd_m;
        r_neg = neg_m;
        r_ovf = ovf_m;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({if_a.busy, if_a.done, if_a.neg, if_a.ovf, if_a.bcd} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_a: got %h want 0", {if_a.busy, if_a.done, if_a.neg, if_a.ovf, if_a.bcd});
    end
    n_cmp++;
    if ({if_b.busy, if_b.done, if_b.neg, if_b.ovf, if_b.bcd} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_b: got %h want 0", {if_b.busy, if_b.done, if_b.neg, if_b.ovf, if_b.bcd});
    end
    n_cmp++;
    if ({if_c.busy, if_c.done, if_c.neg, if_c.ovf, if_c.bcd} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_c: got %h want 0", {if_c.busy, if_c.done, if_c.neg, if_c.ovf, if_c.bcd});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [19:0] b;
    logic n, o;
    int lat, bc;
    convert(0, 16'd1234, b, n, o, lat, bc);
    n_cmp++;
    if (lat !== 17) begin n_err++; $display("FAIL basic_latency: got %0d want 17", lat); end
    n_cmp++;
    if (bc !== 17) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 17", bc); end
    n_cmp++;
    if (b !== 20'h01234) begin n_err++; $display("FAIL basic_bcd: got %h want 01234", b); end
    n_cmp++;
    if ({n, o} !== 2'b00) begin n_err++; $display("FAIL basic_neg_ovf: got %b want 00", {n, o}); end
    @(negedge clk);
    n_cmp++;
    if ({busy_m, done_m} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_idle_after: got %b want 00", {busy_m, done_m});
    end
  endtask

  task automatic test_signed();
    logic [19:0] b;
    logic n, o;
    int lat, bc;
    convert(0, 16'hFFFF, b, n, o, lat, bc);
    n_cmp++;
    if ({b, n} !== {20'h00001, 1'b1}) begin
      n_err++; $display("FAIL signed_m1: got %h neg %b want 00001 neg 1", b, n);
    end
    convert(0, 16'h8000, b, n, o, lat, bc);
    n_cmp++;
    if ({b, n, o} !== {20'h32768, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL signed_min: got %h neg %b ovf %b want 32768 1 0", b, n, o);
    end
    convert(0, 16'h0000, b, n, o, lat, bc);
    n_cmp++;
    if ({b, n} !== {20'h00000, 1'b0}) begin
      n_err++; $display("FAIL signed_zero: got %h neg %b want 00000 neg 0", b, n);
    end
  endtask

  task automatic test_unsigned();
    logic [19:0] b;
    logic n, o;
    int lat, bc;
    convert(1, 16'hFFFF, b, n, o, lat, bc);
    n_cmp++;
    if ({b, n, o} !== {20'h65535, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL unsigned_max: got %h neg %b ovf %b want 65535 0 0", b, n, o);
    end
    convert(1, 16'h0000, b, n, o, lat, bc);
    n_cmp++;
    if ({b, n} !== {20'h00000, 1'b0}) begin
      n_err++; $display("FAIL unsigned_zero: got %h neg %b want 00000 0", b, n);
    end
  endtask

  task automatic test_overflow();
    logic [19:0] b;
    logic n, o;
    int lat, bc;
    convert(2, 16'd12345, b, n, o, lat, bc);
    n_cmp++;
    if ({b, o} !== {20'h02345, 1'b1}) begin
      n_err++; $display("FAIL ovf_12345: got %h ovf %b want 2345 ovf 1", b, o);
    end
    convert(2, 16'd9999, b, n, o, lat, bc);
    n_cmp++;
    if ({b, o} !== {20'h09999, 1'b0}) begin
      n_err++; $display("FAIL ovf_9999: got %h ovf %b want 9999 ovf 0", b, o);
    end
  endtask

  task automatic test_start_ignored();
    logic [19:0] b;
    logic n, o;
    int lat, bc;
    sel = 0;
    lat = -1;
    b = '0;
    @(negedge clk);
    value_r = 16'd42;
    start_r[0] = 1'b1;
    @(posedge clk);
    #1 start_r[0] = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5) begin
        value_r = 16'd999;
        start_r[0] = 1'b1;
      end else begin
        start_r[0] = 1'b0;
      end
      if (done_m) begin
        lat = i;
        b = bcd_m;
        break;
      end
    end
    start_r[0] = 1'b0;
    n_cmp++;
    if ({lat, b} !== {32'd17, 20'h00042}) begin
      n_err++; $display("FAIL busy_start_ignored: got lat %0d bcd %h want 17 00042", lat, b);
    end
    convert(0, 16'd999, b, n, o, lat, bc);
    n_cmp++;
    if (b !== 20'h00999) begin
      n_err++; $display("FAIL after_ignored_999: got %h want 00999", b);
    end
  endtask

  task automatic test_back_to_back();
    int first, second;
    logic [19:0] hold_bcd, second_bcd;
    sel = 0;
    first = -1;
    second = -1;
    hold_bcd = '0;
    second_bcd = '0;
    @(negedge clk);
    value_r = 16'd7;
    start_r[0] = 1'b1;
    for (int i = 1; i <= 37; i++) begin
      @(negedge clk);
      if (done_m) begin
        if (first < 0) begin
          first = i;
        end else if (second < 0) begin
          second = i;
          second_bcd = bcd_m;
        end
      end
      if (i == 17) value_r = 16'd8;
      if (i == 30) hold_bcd = bcd_m;
      if (i == 35) start_r[0] = 1'b0;
    end
    n_cmp++;
    if ({first, second} !== {32'd17, 32'd35}) begin
      n_err++; $display("FAIL b2b_done_cycles: got %0d,%0d want 17,35", first, second);
    end
    n_cmp++;
    if (hold_bcd !== 20'h00007) begin
      n_err++; $display("FAIL b2b_hold: got %h want 00007", hold_bcd);
    end
    n_cmp++;
    if (second_bcd !== 20'h00008) begin
      n_err++; $display("FAIL b2b_second: got %h want 00008", second_bcd);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] b;
    logic n, o;
    int lat, bc, dones;
    sel = 0;
    @(negedge clk);
    value_r = 16'd500;
    start_r[0] = 1'b1;
    @(posedge clk);
    #1 start_r[0] = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({if_a.busy, if_a.done} !== 2'b00) begin
      n_err++; $display("FAIL midreset_busy_done: got %b want 00", {if_a.busy, if_a.done});
    end
    n_cmp++;
    if ({if_a.bcd, if_a.neg, if_a.ovf} !== 22'h0) begin
      n_err++; $display("FAIL midreset_outputs: got %h want 0", {if_a.bcd, if_a.neg, if_a.ovf});
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_m || busy_m) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++; $display("FAIL midreset_no_done: got %0d active cycles want 0", dones);
    end
    convert(0, 16'd77, b, n, o, lat, bc);
    n_cmp++;
    if ({lat, b} !== {32'd17, 20'h00077}) begin
      n_err++; $display("FAIL midreset_recover: got lat %0d bcd %h want 17 00077", lat, b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_unsigned();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
